// File: rtl/gray_counter.sv
// Registered up/down Gray counter with load and wrap/saturate. Latency 1 cycle from inputs to all outputs;
// no backpressure: a step is accepted on every clock. A load may change several Gray bits at once.
module gray_counter #(
    parameter int WIDTH = 8,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_gray_i,
    output logic [WIDTH-1:0] gray_o,
    output logic [WIDTH-1:0] binary_o,
    output logic             over_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_gry;
    logic             r_ovr;

    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_gry_nxt;
    logic             w_ovr_nxt;

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        w_load_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_load_bin[i] = ^(load_gray_i >> i);
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovr_nxt = 1'b0;
        if (load_i) begin
            w_cnt_nxt = w_load_bin;
        end else if (en_i && up_i) begin
            if (r_cnt == CNT_MAX) begin
                w_ovr_nxt = 1'b1;
                w_cnt_nxt = WRAP ? '0 : r_cnt;
            end else begin
                w_cnt_nxt = r_cnt + WIDTH'(1);
            end
        end else if (en_i) begin
            if (r_cnt == '0) begin
                w_ovr_nxt = 1'b1;
                w_cnt_nxt = WRAP ? CNT_MAX : r_cnt;
            end else begin
                w_cnt_nxt = r_cnt - WIDTH'(1);
            end
        end
        w_gry_nxt = w_cnt_nxt ^ (w_cnt_nxt >> 1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
            r_gry <= '0;
            r_ovr <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_gry <= w_gry_nxt;
            r_ovr <= w_ovr_nxt;
        end
    end

    assign gray_o   = r_gry;
    assign binary_o = r_cnt;
    assign over_o   = r_ovr;

endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised registered Gray-code counter, the next generation of the combinational binary-to-Gray encoder in the standard library. It keeps a binary count internally and presents a registered, glitch-free Gray-coded value. Exactly one Gray bit changes per step. It adds enable, up/down direction, parallel load of a Gray-coded value and a selectable wrap or saturate mode. It is intended for pointers, position counters and any value that later crosses a clock or domain boundary.

## Interface
- WIDTH, 8, counter width in bits; legal range WIDTH >= 2.
- WRAP, 1, 1 = modulo-2^WIDTH wrap-around; 0 = saturate at the boundary in the current direction.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- en_i  input  1  count enable; one step per cycle while high.
- up_i  input  1  direction, sampled with en_i: 1 = increment, 0 = decrement.
- load_i  input  1  parallel load strobe; takes priority over en_i.
- load_gray_i  input  WIDTH  value to load, Gray-coded.
- gray_o  output  WIDTH  current count, Gray-coded, driven directly from flops.
- binary_o  output  WIDTH  current count, binary, driven from flops.
- over_o  output  1  one-cycle pulse: the previous step crossed or hit the boundary.

## Operation
- State: binary register cnt[WIDTH-1:0], Gray register gry[WIDTH-1:0] and flop ovr.
- Invariant: gry == cnt ^ (cnt >> 1) at every clock edge.
- gray_o = gry; binary_o = cnt; over_o = ovr. There is no combinational path from any input to any output.
- Next-state priority, evaluated each rising edge:
  1. load_i = 1: cnt <= gray2bin(load_gray_i) and ovr <= 0. en_i and up_i are ignored.
  2. en_i = 1, up_i = 1, cnt != 2^WIDTH-1: cnt <= cnt+1, ovr <= 0.
  3. en_i = 1, up_i = 1, cnt == 2^WIDTH-1: if WRAP=1, cnt <= 0; if WRAP=0, cnt holds. ovr <= 1 in both cases.
  4. en_i = 1, up_i = 0, cnt != 0: cnt <= cnt-1, ovr <= 0.
  5. en_i = 1, up_i = 0, cnt == 0: if WRAP=1, cnt <= 2^WIDTH-1; if WRAP=0, cnt holds. ovr <= 1 in both cases.
  6. Otherwise: cnt and gry hold, ovr <= 0.
- gray2bin is a prefix XOR from the MSB: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
- The gry next value is bin2gray(next cnt), computed in the same cycle and registered alongside cnt.
- Arithmetic is unsigned, WIDTH bits. No carry or borrow is kept beyond ovr.
- In saturate mode, an attempt to step past the boundary is reported on over_o even though the count does not change.

## Timing
- Reset (rst_ni low, asynchronous): cnt = 0, gry = 0, ovr = 0. Outputs go low without waiting for a clock edge and stay low while rst_ni is low.
- Release: the first rising edge with rst_ni high is the first edge at which state can change.
- Reset asserted mid-count forces zero immediately. Any step in progress is discarded.
- Latency: 1 cycle. Inputs sampled at edge N appear on gray_o, binary_o and over_o after edge N.
- over_o is high for exactly one cycle per boundary step. Continuous enable at saturation gives over_o high on every cycle.
- Successive gray_o values from a count step differ in exactly one bit, including across wrap.
- A load may change several bits at once. This is legal and must be documented to downstream consumers.
- Throughput: one step per clock; there are no bubbles.

## Test plan
- Reset and up-count, WIDTH=4, WRAP=1: release reset, en_i=1, up_i=1 for 17 cycles. gray_o must read 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0 (hex). over_o must pulse only on the cycle showing 0 after 8. Exactly one bit may change per step.
- Down-count wrap, WIDTH=4, WRAP=1: from reset, en_i=1, up_i=0 for one cycle. Required: gray_o=8, binary_o=F, over_o=1. The next step must give gray_o=9, binary_o=E, over_o=0.
- Load priority: load_i=1, load_gray_i=B, en_i=1, up_i=1 in the same cycle. Required: binary_o=D, gray_o=B, over_o=0. Next cycle, with en_i only, gray_o=A.
- Saturate, WIDTH=4, WRAP=0: load_gray_i=8 (binary F), then en_i=1, up_i=1 for 3 cycles. gray_o must stay 8 and over_o must read 1,1,1. Drop en_i and over_o must return to 0. Repeat at 0 with up_i=0: gray_o stays 0.
- Async reset mid-count: assert rst_ni low between clock edges while gray_o=6. gray_o, binary_o and over_o must go to 0 before the next edge and hold while reset is asserted.
- Random regression, WIDTH=8 and WIDTH=2, both WRAP values: random en_i, up_i and load_i for 10k cycles against a reference model. Check gray_o == binary_o ^ (binary_o >> 1) on every cycle.
